// File: rtl/lsu_dmem_port.sv
// Load/store unit between the memory stage and a valid/ready data memory.
// One request at a time: aligned requests go to memory, misaligned ones are answered locally.
module lsu_dmem_port #(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_timeout,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(WAIT_TIMEOUT - 1);

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lo[0];
      2'b10:   misaligned = (lo != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_we = 4'b0001 << off;
      2'b01:   store_we = 4'b0011 << off;
      default: store_we = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      2'b00:   load_extract = uns ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_extract = uns ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_extract = lane;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [29:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        capture;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    to_d    = to_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mis_d   = misaligned(req_size, req_addr[1:0]);
          to_d    = 1'b0;
          state_d = mis_d ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = is_store_q ? RESP : WAIT;
          cnt_d   = 8'd0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = RESP;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          to_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // control state: asynchronously reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      if (accept) is_store_q <= req_is_store;
    end
  end

  // datapath registers: outputs are gated by state, so no reset is needed
  always_ff @(posedge clk) begin
    if (accept) begin
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      off_q   <= req_addr[1:0];
      addr_q  <= req_addr[31:2];
      we_q    <= req_is_store ? store_we(req_size, req_addr[1:0]) : 4'b0000;
      wdata_q <= req_is_store ? store_data(req_size, req_wdata) : 32'd0;
      rdata_q <= 32'd0;
    end else if (capture) begin
      rdata_q <= load_extract(size_q, uns_q, off_q, mem_rdata);
    end
  end

  assign req_ready       = (state_q == IDLE);
  assign mem_valid       = (state_q == ISSUE);
  assign mem_addr        = mem_valid ? {addr_q, 2'b00} : 32'd0;
  assign mem_we          = mem_valid ? we_q : 4'b0000;
  assign mem_wdata       = mem_valid ? wdata_q : 32'd0;
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = resp_valid ? rdata_q : 32'd0;
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_timeout    = resp_valid && to_q;

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port: stores, loads, misalignment, backpressure, timeout, reset.
module tb_lsu_dmem_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_timeout;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_dmem_port #(.WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_timeout(resp_timeout),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Called at a negedge in IDLE; returns at the negedge of the first cycle after acceptance.
  task automatic issue_req(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd);
    req_is_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_size = 2'b11;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if ({req_ready, mem_valid, resp_valid, resp_misaligned, resp_timeout} !== 5'b10000) begin n_err++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, mem_valid, resp_valid, resp_misaligned, resp_timeout}); end
    n_vec++; if ({mem_addr, mem_we, mem_wdata, resp_rdata} !== 100'd0) begin n_err++; $display("FAIL reset_data: got %h/%h/%h/%h expected zeros", mem_addr, mem_we, mem_wdata, resp_rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_store(input string nm, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] exp_we, input logic [31:0] exp_wd);
    mem_ready = 1'b1;
    issue_req(1'b1, sz, 1'b0, a, wd);
    n_vec++; if ({mem_valid, req_ready, resp_valid} !== 3'b100) begin n_err++; $display("FAIL %s_issue: got valid/ready/resp %b expected 100", nm, {mem_valid, req_ready, resp_valid}); end
    n_vec++; if ({mem_addr, mem_we, mem_wdata} !== {a[31:2], 2'b00, exp_we, exp_wd}) begin n_err++; $display("FAIL %s_lanes: got %h %b %h expected %h %b %h", nm, mem_addr, mem_we, mem_wdata, {a[31:2], 2'b00}, exp_we, exp_wd); end
    @(negedge clk);
    n_vec++; if ({resp_valid, resp_misaligned, resp_timeout, resp_rdata, mem_valid} !== {3'b100, 32'd0, 1'b0}) begin n_err++; $display("FAIL %s_resp: got v%b m%b t%b %h mv%b expected resp with rdata 0", nm, resp_valid, resp_misaligned, resp_timeout, resp_rdata, mem_valid); end
    @(negedge clk);
    n_vec++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL %s_done: got resp/ready %b expected 01", nm, {resp_valid, req_ready}); end
  endtask

  task automatic do_load(input string nm, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp);
    mem_ready = 1'b1;
    issue_req(1'b0, sz, un, a, 32'hA5A5_A5A5);
    n_vec++; if ({mem_valid, mem_we, mem_addr} !== {1'b1, 4'b0000, a[31:2], 2'b00}) begin n_err++; $display("FAIL %s_issue: got %b %b %h expected 1 0000 %h", nm, mem_valid, mem_we, mem_addr, {a[31:2], 2'b00}); end
    @(negedge clk);
    n_vec++; if ({mem_valid, resp_valid} !== 2'b00) begin n_err++; $display("FAIL %s_wait: got mem_valid/resp %b expected 00", nm, {mem_valid, resp_valid}); end
    mem_rvalid = 1'b1; mem_rdata = word;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_vec++; if ({resp_valid, resp_misaligned, resp_timeout, resp_rdata} !== {3'b100, exp}) begin n_err++; $display("FAIL %s_resp: got v%b m%b t%b %h expected v1 m0 t0 %h", nm, resp_valid, resp_misaligned, resp_timeout, resp_rdata, exp); end
    @(negedge clk);
    n_vec++; if ({resp_valid, req_ready, resp_rdata} !== {2'b01, 32'd0}) begin n_err++; $display("FAIL %s_done: got resp/ready %b rdata %h expected 01 0", nm, {resp_valid, req_ready}, resp_rdata); end
  endtask

  task automatic test_store;
    do_store("st_byte", 2'b00, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    do_store("st_half", 2'b01, 32'h0000_0102, 32'h1234_CDEF, 4'b1100, 32'hCDEF_CDEF);
    do_store("st_word", 2'b10, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
  endtask

  task automatic test_load;
    do_load("ld_byte_s", 2'b00, 1'b0, 32'h0000_0102, 32'h00F4_0000, 32'hFFFF_FFF4);
    do_load("ld_byte_u", 2'b00, 1'b1, 32'h0000_0102, 32'h00F4_0000, 32'h0000_00F4);
    do_load("ld_byte3_s", 2'b00, 1'b0, 32'h0000_0203, 32'h7F00_0080, 32'h0000_007F);
    do_load("ld_half_u", 2'b01, 1'b1, 32'h0000_0006, 32'h8001_1234, 32'h0000_8001);
    do_load("ld_half_s", 2'b01, 1'b0, 32'h0000_0004, 32'h1234_8001, 32'hFFFF_8001);
    do_load("ld_word", 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
  endtask

  task automatic test_misaligned;
    logic [1:0]  szs [2];
    logic [31:0] adr [2];
    szs[0] = 2'b10; adr[0] = 32'h0000_0102;
    szs[1] = 2'b11; adr[1] = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      issue_req(i[0], szs[i], 1'b0, adr[i], 32'h1111_2222);
      n_vec++; if ({mem_valid, resp_valid, resp_misaligned, resp_timeout, resp_rdata} !== {4'b0110, 32'd0}) begin n_err++; $display("FAIL misalign%0d_resp: got mv%b v%b m%b t%b %h expected mv0 v1 m1 t0 0", i, mem_valid, resp_valid, resp_misaligned, resp_timeout, resp_rdata); end
      @(negedge clk);
      n_vec++; if ({mem_valid, resp_valid, resp_misaligned, req_ready} !== 4'b0001) begin n_err++; $display("FAIL misalign%0d_done: got %b expected 0001", i, {mem_valid, resp_valid, resp_misaligned, req_ready}); end
    end
  endtask

  task automatic test_backpressure;
    int nresp = 0;
    mem_ready = 1'b0;
    issue_req(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      n_vec++; if ({mem_valid, req_ready, resp_valid, mem_addr, mem_we, mem_wdata} !== {3'b100, 32'h20, 4'b1111, 32'h1122_3344}) begin n_err++; $display("FAIL bp_hold%0d: got %b %h %b %h expected 100 00000020 1111 11223344", i, {mem_valid, req_ready, resp_valid}, mem_addr, mem_we, mem_wdata); end
      if (i == 4) mem_ready = 1'b1;
      @(negedge clk);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid === 1'b1) nresp++;
      @(negedge clk);
    end
    n_vec++; if (nresp !== 1) begin n_err++; $display("FAIL bp_single_resp: got %0d responses expected 1", nresp); end
    n_vec++; if ({req_ready, mem_valid} !== 2'b10) begin n_err++; $display("FAIL bp_idle: got ready/mem_valid %b expected 10", {req_ready, mem_valid}); end
  endtask

  task automatic test_timeout;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    issue_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({resp_valid, mem_valid} !== 2'b00) begin n_err++; $display("FAIL to_wait%0d: got resp/mem_valid %b expected 00", i, {resp_valid, mem_valid}); end
      @(negedge clk);
    end
    n_vec++; if ({resp_valid, resp_timeout, resp_misaligned, resp_rdata} !== {3'b110, 32'd0}) begin n_err++; $display("FAIL to_resp: got v%b t%b m%b %h expected v1 t1 m0 0", resp_valid, resp_timeout, resp_misaligned, resp_rdata); end
    @(negedge clk);
    n_vec++; if ({resp_valid, resp_timeout, req_ready} !== 3'b001) begin n_err++; $display("FAIL to_done: got %b expected 001", {resp_valid, resp_timeout, req_ready}); end
    mem_rdata = 32'h0;
  endtask

  task automatic test_reset_mid;
    int nresp = 0;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    issue_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if ({req_ready, mem_valid, resp_valid} !== 3'b100) begin n_err++; $display("FAIL rstmid_async: got %b expected 100", {req_ready, mem_valid, resp_valid}); end
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) nresp++;
    end
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    n_vec++; if ({nresp != 0, req_ready, mem_valid} !== 3'b010) begin n_err++; $display("FAIL rstmid_discard: got %0d responses ready %b mem_valid %b expected 0 1 0", nresp, req_ready, mem_valid); end
    do_load("ld_after_rst", 2'b01, 1'b1, 32'h0000_0012, 32'hBEEF_0000, 32'h0000_BEEF);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    test_reset;
    test_store;
    test_load;
    test_misaligned;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
